fifo_ctrl: RTL and testbench

Pointer and flag controller for the synchronous FIFO. It owns the write and read pointers, which use the team's wrap-counter form of ADDR_WIDTH+1 bits with an extra MSB for full/empty disambiguation. It gates requester write/read strobes into memory enables and publishes occupancy, status flags and sticky error flags. It sits between the FIFO's producer/consumer ports and the dual-port storage array.

---
 rtl/fifo_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for the sync FIFO.
// Wrap-counter pointers carry one extra MSB to tell full from empty.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int AFULL_TH   = 508,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = ADDR_WIDTH;

  localparam logic [AW:0] ZERO    = '0;
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_C = AFULL_TH[AW:0];
  localparam logic [AW:0] AEMPT_C = AEMPTY_TH[AW:0];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        afull_q, afull_d;
  logic        aempty_q, aempty_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  // Gate strobes with registered flags, then derive next pointers/flags.
  always_comb begin
    wr_en    = wr_req & ~full_q & ~flush;
    rd_en    = rd_req & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (flush) begin
      wr_ptr_d = ZERO;
      rd_ptr_d = ZERO;
      count_d  = ZERO;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + ONE;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      // A set condition in the same cycle as clr_err wins.
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (wr_req & full_q)  ovf_d = 1'b1;
      if (rd_req & empty_q) udf_d = 1'b1;
    end

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == ZERO);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPT_C);
  end

  // State register; rst overrides flush and every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= ZERO;
      rd_ptr_q <= ZERO;
      count_q  <= ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_addr      = wr_ptr_q[AW-1:0];
  assign rd_addr      = rd_ptr_q[AW-1:0];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed boundary sequence plus random traffic,
// checked against an integer occupancy/pointer model.
module tb_fifo_ctrl;

  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int AFT   = 508;
  localparam int AET   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          clr_err = 1'b0;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  int m_cnt = 0;
  int m_wr  = 0;
  int m_rd  = 0;
  bit m_ovf = 0;
  bit m_udf = 0;

  fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .AFULL_TH  (AFT),
    .AEMPTY_TH (AET)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .clr_err     (clr_err),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), m_cnt);
    check("full", 32'(full), 32'(m_cnt == DEPTH));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("afull", 32'(almost_full), 32'(m_cnt >= AFT));
    check("aempty", 32'(almost_empty), 32'(m_cnt <= AET));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    check("wr_addr", 32'(wr_addr), m_wr % DEPTH);
    check("rd_addr", 32'(rd_addr), m_rd % DEPTH);
  endtask

  // One clock: drive, check enables, clock, update model, check state.
  task automatic cyc(input bit w, input bit r, input bit f,
                     input bit c, input bit rs);
    bit mf, me, xw, xr;
    wr_req  = w;
    rd_req  = r;
    flush   = f;
    clr_err = c;
    rst     = rs;
    mf = (m_cnt == DEPTH);
    me = (m_cnt == 0);
    xw = w && !mf && !f;
    xr = r && !me && !f;
    #1;
    check("wr_en", 32'(wr_en), 32'(xw));
    check("rd_en", 32'(rd_en), 32'(xr));
    @(posedge clk);
    if (rs) begin
      m_cnt = 0; m_wr = 0; m_rd = 0;
      m_ovf = 0; m_udf = 0;
    end else if (f) begin
      m_cnt = 0; m_wr = 0; m_rd = 0;
    end else begin
      if (xw) begin
        m_wr = (m_wr + 1) % (2 * DEPTH);
        m_cnt++;
      end
      if (xr) begin
        m_rd = (m_rd + 1) % (2 * DEPTH);
        m_cnt--;
      end
      if (c) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (w && mf) m_ovf = 1;
      if (r && me) m_udf = 1;
    end
    #1;
    check_state();
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("ovf_after_fill", 32'(overflow), 1);
    cyc(0, 0, 0, 1, 0);
    check("ovf_cleared", 32'(overflow), 0);
    cyc(1, 0, 0, 1, 0);
    check("ovf_set_wins", 32'(overflow), 1);
    cyc(1, 1, 0, 0, 0);
    check("pair_at_full", 32'(count), DEPTH - 1);
    cyc(1, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("pair_at_empty", 32'(count), 1);
    check("udf_at_empty", 32'(underflow), 1);
    for (int i = 0; i < 99; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) cyc(1, 1, 0, 0, 0);
    check("pair_hold", 32'(count), 100);

    for (int i = 0; i < 63; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("flush_cnt", 32'(count), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);

    for (int i = 0; i < 2400; i++) begin
      int pw, pr;
      case ((i / 600) % 4)
        0: begin pw = 95; pr = 5;  end
        1: begin pw = 5;  pr = 95; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 70; pr = 30; end
      endcase
      cyc($urandom_range(99) < pw,
          $urandom_range(99) < pr,
          $urandom_range(999) < 2,
          $urandom_range(99) < 3,
          $urandom_range(999) < 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
